// File: rtl/aes_pkg.sv
// Shared AES helpers: S-box tables, round constants, GF(2^8) math and the
// decrypt-core state encoding. Also used by aes_encrypt.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    KEXP  = 2'd1,
    ROUND = 2'd2
  } aes_dec_state_t;

  localparam logic [7:0] SBOX_T [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  localparam logic [7:0] INV_SBOX_T [256] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
  };

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_T[b];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_T[b];
  endfunction

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1 (0x11B).
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add GF(2^8) product; with a constant b it folds to an XOR tree.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step in both directions: fwd = rk(r+1) from rk(r),
// inv = rk(r) from rk(r+1). rcon must be rcon[r+1] for either direction.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] rk,
  input  logic [7:0]   rcon,
  output logic [127:0] fwd,
  output logic [127:0] inv
);

  // SubWord(RotWord(w)) ^ Rcon: four forward S-boxes per direction.
  function automatic logic [31:0] g_word(input logic [31:0] w, input logic [7:0] rc);
    return {sbox(w[23:16]) ^ rc, sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] f0, f1, f2, f3;
  logic [31:0] p0, p1, p2, p3;

  assign {w0, w1, w2, w3} = rk;

  // Forward: each word chains off the previous new word.
  assign f0  = w0 ^ g_word(w3, rcon);
  assign f1  = w1 ^ f0;
  assign f2  = w2 ^ f1;
  assign f3  = w3 ^ f2;
  assign fwd = {f0, f1, f2, f3};

  // Inverse: undo the chain from the top; the old w3 feeds the g function.
  assign p3  = w3 ^ w2;
  assign p2  = w2 ^ w1;
  assign p1  = w1 ^ w0;
  assign p0  = w0 ^ g_word(p3, rcon);
  assign inv = {p0, p1, p2, p3};

endmodule

// File: rtl/aes_decrypt.sv
// Iterative AES-128 decryption: 10 cycles of forward key expansion to rk10,
// then 10 inverse rounds stepping the round key backward. 20-cycle latency.
module aes_decrypt
  import aes_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key,
  input  logic         load,
  input  logic [127:0] ct,
  output logic [127:0] pt,
  output logic         valid,
  output logic         busy
);

  if (NK != 4) begin : g_nk_check
    $error("aes_decrypt supports only NK = 4 (AES-128)");
  end

  aes_dec_state_t state, state_nxt;
  logic [3:0]   rnd;
  logic [127:0] rk, ct_q, st;
  logic [127:0] k_fwd, k_inv;
  logic [127:0] isr, t;

  aes_key_step u_key_step (
    .rk   (rk),
    .rcon (RCON[rnd + 4'd1]),
    .fwd  (k_fwd),
    .inv  (k_inv)
  );

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = s;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  // Round datapath: InvShiftRows (row r rotates right by r), InvSubBytes, AddRoundKey.
  always_comb begin
    // NOTE: full defaults first so every path assigns every bit and no latch is inferred.
    isr = st;
    t   = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        isr[127-8*(4*c+r) -: 8] = st[127-8*(4*((c-r)&3)+r) -: 8];
      end
    end
    for (int i = 0; i < 16; i++) begin
      t[127-8*i -: 8] = inv_sbox(isr[127-8*i -: 8]) ^ k_inv[127-8*i -: 8];
    end
  end

  // Next-state: load in IDLE, 10 expansion cycles, 10 rounds, back to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = KEXP;
      KEXP:    if (rnd == 4'd9) state_nxt = ROUND;
      ROUND:   if (rnd == 4'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Control and result registers: round counter, plaintext, valid pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rnd   <= 4'd0;
      pt    <= '0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE:  if (load) rnd <= 4'd0;
        KEXP:  if (rnd != 4'd9) rnd <= rnd + 4'd1;
        ROUND: begin
          if (rnd == 4'd0) begin
            pt    <= t;
            valid <= 1'b1;
          end else begin
            rnd <= rnd - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Key/state datapath; contents only matter once the FSM has loaded them.
  always_ff @(posedge clk) begin
    // NOTE: wide datapath registers are deliberately left unreset; the FSM reset alone makes them don't-care.
    case (state)
      IDLE: if (load) begin
        rk   <= key;
        ct_q <= ct;
      end
      KEXP: begin
        rk <= k_fwd;
        if (rnd == 4'd9) st <= ct_q ^ k_fwd;
      end
      ROUND: begin
        rk <= k_inv;
        st <= inv_mix(t);
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_aes_decrypt.sv
// Directed bench for aes_decrypt: FIPS-197 vectors, round trip through a
// behavioral encryptor, busy/load handling, back-to-back and mid-run reset.
module tb_aes_decrypt;
  import aes_pkg::*;

  localparam logic [127:0] KC1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CC1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PC1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KB   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CB   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PB   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] RKB  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KRT  = 128'hfefd00d583ef87e9b7e6ab3a655f68db;
  localparam logic [127:0] PRT  = 128'h05060708090a0b0c0d0e0f1011121314;
  localparam logic [30:0]  VEXP = 31'h0010_0000;  // valid only after E20
  localparam logic [30:0]  BEXP = 31'h000F_FFFF;  // busy after E0..E19

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] ct = '0;
  logic [127:0] pt;
  logic         valid;
  logic         busy;

  int checks = 0;
  int errors = 0;

  aes_decrypt #(.NK(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .key   (key),
    .load  (load),
    .ct    (ct),
    .pt    (pt),
    .valid (valid),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioral AES-128 encryptor used to produce the round-trip ciphertext.
  function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] p);
    logic [127:0] s, rk, q, m;
    logic [31:0]  g, n0, n1, n2, n3;
    logic [7:0]   a0, a1, a2, a3;
    rk = k;
    s  = p ^ rk;
    for (int r = 1; r <= 10; r++) begin
      g  = {sbox(rk[23:16]) ^ RCON[r], sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])};
      n0 = rk[127:96] ^ g;
      n1 = rk[95:64] ^ n0;
      n2 = rk[63:32] ^ n1;
      n3 = rk[31:0] ^ n2;
      rk = {n0, n1, n2, n3};
      q  = s;
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++)
          q[127-8*(4*c+w) -: 8] = sbox(s[127-8*(4*((c+w)%4)+w) -: 8]);
      m = q;
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = q[127-32*c -: 8];
          a1 = q[119-32*c -: 8];
          a2 = q[111-32*c -: 8];
          a3 = q[103-32*c -: 8];
          m[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
          m[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
          m[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
          m[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
      end
      s = m ^ rk;
    end
    return s;
  endfunction

  // Load one block, then watch 30 edges. With disturb set, ct changes after
  // E1 and a second load with other key/ct is presented at E5.
  task automatic run_block(input logic [127:0] k, input logic [127:0] c, input bit disturb,
                           output logic [127:0] res, output logic [30:0] vt,
                           output logic [30:0] bt, output logic [127:0] rk10);
    key  = k;
    ct   = c;
    load = 1'b1;
    step();  // E0
    load = 1'b0;
    res  = '0;
    rk10 = '0;
    vt   = '0;
    bt   = '0;
    bt[0] = busy;
    for (int i = 1; i <= 30; i++) begin
      if (disturb && i == 2) ct = ~c;
      if (disturb && i == 5) begin
        load = 1'b1;
        key  = ~k;
        ct   = c ^ 128'h1;
      end
      if (disturb && i == 6) load = 1'b0;
      step();
      if (i == 10) rk10 = dut.rk;
      vt[i] = valid;
      bt[i] = busy;
      if (valid && res == '0) res = pt;
    end
  endtask

  logic [127:0] res, rk10, ct_rt;
  logic [30:0]  vt, bt;
  logic [65:0]  vt66, vexp66;
  int           late_valid;

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (3) step();
    check("rst_pt", pt, '0);
    check("rst_valid", 128'(valid), 128'(1'b0));
    check("rst_busy", 128'(busy), 128'(1'b0));
    rst_n = 1'b1;
    step();

    // FIPS-197 C.1
    run_block(KC1, CC1, 1'b0, res, vt, bt, rk10);
    check("c1_pt", res, PC1);
    check("c1_valid_trace", 128'(vt), 128'(VEXP));
    check("c1_busy_trace", 128'(bt), 128'(BEXP));
    check("c1_pt_held", pt, PC1);

    // FIPS-197 Appendix B with round-key-10 probe
    run_block(KB, CB, 1'b0, res, vt, bt, rk10);
    check("appb_pt", res, PB);
    check("appb_valid_trace", 128'(vt), 128'(VEXP));
    check("appb_rk10", rk10, RKB);

    // Round trip through the behavioral encryptor
    ct_rt = aes_enc(KRT, PRT);
    run_block(KRT, ct_rt, 1'b0, res, vt, bt, rk10);
    check("rt_pt", res, PRT);
    check("rt_valid_trace", 128'(vt), 128'(VEXP));

    // Load while busy and ct change after load are ignored
    run_block(KC1, CC1, 1'b1, res, vt, bt, rk10);
    check("busy_pt", res, PC1);
    check("busy_valid_once", 128'(vt), 128'(VEXP));
    check("busy_busy_trace", 128'(bt), 128'(BEXP));

    // Back-to-back: load held high for 50 sampled edges
    key  = KB;
    ct   = CB;
    load = 1'b1;
    step();  // E0
    vt66 = '0;
    for (int i = 1; i <= 65; i++) begin
      if (i == 50) load = 1'b0;
      step();
      vt66[i] = valid;
      if (valid) check("b2b_pt", pt, PB);
      if (i == 30) check("b2b_pt_stable", pt, PB);
    end
    vexp66 = '0;
    vexp66[20] = 1'b1;
    vexp66[41] = 1'b1;
    vexp66[62] = 1'b1;
    check("b2b_valid_trace", 128'(vt66), 128'(vexp66));

    // Reset at E12 aborts the block
    key  = KC1;
    ct   = CC1;
    load = 1'b1;
    step();  // E0
    load = 1'b0;
    repeat (11) step();  // E1..E11
    rst_n = 1'b0;
    step();  // E12
    check("abort_busy", 128'(busy), 128'(1'b0));
    check("abort_valid", 128'(valid), 128'(1'b0));
    check("abort_pt", pt, '0);
    rst_n = 1'b1;
    late_valid = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (valid) late_valid++;
    end
    check("abort_no_valid", 128'(late_valid), 128'(0));

    // Fresh load after the abort
    run_block(KC1, CC1, 1'b0, res, vt, bt, rk10);
    check("fresh_pt", res, PC1);
    check("fresh_valid_trace", 128'(vt), 128'(VEXP));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
